// File: rtl/cloud_spawner_if.sv
// cloud_spawner_if
// Bundles the spawner's control inputs and sprite outputs so the colour
// mapper side and the spawner share one connection.
//   run, speed         : frame-advance enable and scroll step (driven by game logic)
//   CloudX, CloudY     : cloud centre position
//   CloudS             : cloud half-size
//   CloudVisible       : any part of the cloud is on screen
//   spawn_pulse        : one-frame strobe after each spawn
// modport master : the spawner itself (drives the sprite outputs)
// modport slave  : game logic / colour mapper side
interface cloud_spawner_if;
  logic       run;
  logic [2:0] speed;
  logic [9:0] CloudX;
  logic [9:0] CloudY;
  logic [9:0] CloudS;
  logic       CloudVisible;
  logic       spawn_pulse;

  modport master (
    input  run, speed,
    output CloudX, CloudY, CloudS, CloudVisible, spawn_pulse
  );

  modport slave (
    output run, speed,
    input  CloudX, CloudY, CloudS, CloudVisible, spawn_pulse
  );
endinterface

// File: rtl/cloud_spawner.sv
// cloud_spawner
// Spawns a single background cloud off the right edge at a pseudo-random
// height, scrolls it left one step per frame and, after it has fully left the
// screen, waits a pseudo-random number of frames before respawning it.
// Ports:
//   frame_clk : one rising edge per video frame
//   Reset     : asynchronous, active-high
//   bus       : cloud_spawner_if.master (run/speed in, sprite outputs out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_WAIT   | cloud off screen, delay counting down to the next spawn
// ST_SCROLL | cloud moving left by step pixels per frame
module cloud_spawner #(
  parameter int         CLOUD_SIZE = 50,
  parameter int         SCREEN_W   = 640,
  parameter int         Y_MIN      = 260,
  parameter int         DELAY_MIN  = 30,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input logic frame_clk,
  input logic Reset,
  cloud_spawner_if.master bus
);

  typedef enum logic {ST_WAIT, ST_SCROLL} state_t;

  localparam int                X_SPAWN    = SCREEN_W + CLOUD_SIZE;
  localparam logic signed [10:0] X_SPAWN_11 = 11'(X_SPAWN);
  localparam logic signed [11:0] CS_12      = 12'(CLOUD_SIZE);
  localparam logic signed [11:0] SW_12      = 12'(SCREEN_W);
  localparam logic [9:0]         Y_MIN_10   = 10'(Y_MIN);
  localparam logic [7:0]         DMIN_8     = 8'(DELAY_MIN);

  state_t            state;
  logic signed [10:0] x_pos;
  logic [9:0]        y_pos;
  logic [7:0]        delay;
  logic [7:0]        lfsr;
  logic              spawn_q;

  logic [2:0]         step;
  logic signed [11:0] x_ext;
  logic signed [11:0] x_next;
  logic               exit_now;
  logic               lfsr_fb;

  // A speed of 0 would stall the cloud forever, so it is promoted to 1.
  assign step     = (bus.speed == 3'd0) ? 3'd1 : bus.speed;
  // 12-bit signed arithmetic leaves headroom so the edge tests never overflow.
  assign x_ext    = {x_pos[10], x_pos};
  assign x_next   = x_ext - $signed({9'd0, step});
  assign exit_now = (x_next + CS_12) <= 12'sd0;
  assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_WAIT;
      delay   <= DMIN_8;
      lfsr    <= LFSR_SEED;
      x_pos   <= X_SPAWN_11;
      y_pos   <= Y_MIN_10;
      spawn_q <= 1'b0;
    end else begin
      spawn_q <= 1'b0;
      if (bus.run) begin
        lfsr <= {lfsr[6:0], lfsr_fb};
        case (state)
          ST_WAIT: begin
            if (delay != 8'd0) begin
              delay <= delay - 8'd1;
            end else begin
              y_pos   <= Y_MIN_10 + {4'd0, lfsr[5:0]};
              x_pos   <= X_SPAWN_11;
              state   <= ST_SCROLL;
              spawn_q <= 1'b1;
            end
          end
          ST_SCROLL: begin
            if (exit_now) begin
              state <= ST_WAIT;
              x_pos <= X_SPAWN_11;
              delay <= DMIN_8 + {4'd0, lfsr[3:0]};
            end else begin
              x_pos <= x_next[10:0];
            end
          end
          default: state <= ST_WAIT;
        endcase
      end
    end
  end

  assign bus.CloudX       = x_pos[9:0];
  assign bus.CloudY       = y_pos;
  assign bus.CloudS       = 10'(CLOUD_SIZE);
  assign bus.spawn_pulse  = spawn_q;
  assign bus.CloudVisible = (state == ST_SCROLL) &&
                            ((x_ext - CS_12) < SW_12) &&
                            ((x_ext + CS_12) > 12'sd0);

endmodule

// File: tb/tb_cloud_spawner.sv
// tb_cloud_spawner
// Directed bench for cloud_spawner: reset values, spawn timing, scroll
// sequence to the left edge, speed changes, run freeze, async reset and
// several full spawn cycles.
module tb_cloud_spawner;
  logic frame_clk = 1'b0;
  logic Reset;

  cloud_spawner_if bus ();

  cloud_spawner dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic       run;
    logic [2:0] speed;
    int         n;
    int         exp_x;
    logic       exp_vis;
    logic       exp_pulse;
  } vec_t;

  vec_t vt[7];

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] m_lfsr;
  logic [7:0] pre_lfsr;

  function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input logic r);
    bus.run  = r;
    pre_lfsr = m_lfsr;
    @(posedge frame_clk);
    #1;
    if (r) m_lfsr = lfsr_nx(m_lfsr);
  endtask

  // Runs edges until spawn_pulse; returns edge count (or -1 on budget expiry).
  task automatic run_to_pulse(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1'b1);
      if (bus.spawn_pulse) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int y1, d, len, bad, found, yexp;

    vt[0] = '{1'b1, 3'd2, 1,   688, 1'b1, 1'b0};
    vt[1] = '{1'b1, 3'd2, 1,   686, 1'b1, 1'b0};
    vt[2] = '{1'b1, 3'd2, 98,  490, 1'b1, 1'b0};
    vt[3] = '{1'b1, 3'd2, 200, 90,  1'b1, 1'b0};
    vt[4] = '{1'b1, 3'd2, 50,  -10, 1'b1, 1'b0};
    vt[5] = '{1'b1, 3'd2, 19,  -48, 1'b1, 1'b0};
    vt[6] = '{1'b1, 3'd2, 1,   690, 1'b0, 1'b0};

    Reset     = 1'b1;
    bus.run   = 1'b0;
    bus.speed = 3'd1;
    m_lfsr    = 8'hA5;
    pre_lfsr  = 8'hA5;
    #12;
    chk("rst_x", bus.CloudX, 690);
    chk("rst_y", bus.CloudY, 260);
    chk("rst_s", bus.CloudS, 50);
    chk("rst_vis", bus.CloudVisible, 0);
    chk("rst_pulse", bus.spawn_pulse, 0);
    chk("lfsr_example", lfsr_nx(m_lfsr), 8'h4A);
    Reset = 1'b0;

    // First spawn after 31 edges
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1);
      if (bus.spawn_pulse) bad++;
    end
    chk("first_wait_pulse_low", bad, 0);
    tick(1'b1);
    y1 = 260 + int'(pre_lfsr[5:0]);
    chk("spawn1_pulse", bus.spawn_pulse, 1);
    chk("spawn1_x", bus.CloudX, 690);
    chk("spawn1_y", bus.CloudY, y1);
    chk("spawn1_vis", bus.CloudVisible, 0);

    // Scroll at speed 2 to the left edge and out
    for (int k = 0; k < 7; k++) begin
      bus.speed = vt[k].speed;
      for (int j = 0; j < vt[k].n; j++) tick(vt[k].run);
      chk($sformatf("vec%0d_x", k), bus.CloudX, vt[k].exp_x & 1023);
      chk($sformatf("vec%0d_vis", k), bus.CloudVisible, vt[k].exp_vis);
      chk($sformatf("vec%0d_pulse", k), bus.spawn_pulse, vt[k].exp_pulse);
      chk($sformatf("vec%0d_y", k), bus.CloudY, y1);
    end
    d = 30 + int'(pre_lfsr[3:0]);

    // Freeze mid-WAIT, then finish the wait
    for (int i = 0; i < 5; i++) tick(1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      if (bus.spawn_pulse || bus.CloudVisible) bad++;
    end
    chk("wait_freeze_quiet", bad, 0);
    run_to_pulse(100, len);
    chk("wait_len_after_freeze", 5 + len, d + 1);
    chk("spawn2_y", bus.CloudY, 260 + int'(pre_lfsr[5:0]));

    // Speed 0 acts as 1, then 7
    bus.speed = 3'd0;
    tick(1'b1); chk("spd0_a", bus.CloudX, 689);
    chk("spd0_vis", bus.CloudVisible, 1);
    tick(1'b1); chk("spd0_b", bus.CloudX, 688);
    bus.speed = 3'd7;
    tick(1'b1); chk("spd7_a", bus.CloudX, 681);
    tick(1'b1); chk("spd7_b", bus.CloudX, 674);

    // Freeze mid-SCROLL
    yexp = bus.CloudY;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      if (bus.CloudX != 10'd674 || bus.spawn_pulse || bus.CloudY != 10'(yexp)) bad++;
    end
    chk("scroll_freeze_hold", bad, 0);
    tick(1'b1); chk("scroll_resume", bus.CloudX, 667);
    tick(1'b1); chk("scroll_resume2", bus.CloudX, 660);

    // Async reset between edges mid-SCROLL
    #2 Reset = 1'b1;
    #1;
    chk("areset_x", bus.CloudX, 690);
    chk("areset_y", bus.CloudY, 260);
    chk("areset_vis", bus.CloudVisible, 0);
    chk("areset_pulse", bus.spawn_pulse, 0);
    Reset  = 1'b0;
    m_lfsr = 8'hA5;
    run_to_pulse(100, len);
    chk("areset_spawn_edges", len, 31);
    chk("areset_spawn_y", bus.CloudY, y1);

    // Three full spawn cycles at speed 7
    bus.speed = 3'd7;
    for (int c = 0; c < 3; c++) begin
      found = 0;
      for (int i = 0; i < 200; i++) begin
        tick(1'b1);
        if (bus.CloudX == 10'd690 && !bus.CloudVisible) begin
          found = 1;
          break;
        end
      end
      chk($sformatf("cyc%0d_exit", c), found, 1);
      d = 30 + int'(pre_lfsr[3:0]);
      run_to_pulse(100, len);
      chk($sformatf("cyc%0d_wait_len", c), len, d + 1);
      chk($sformatf("cyc%0d_wait_range", c), int'(len >= 31 && len <= 46), 1);
      chk($sformatf("cyc%0d_y", c), bus.CloudY, 260 + int'(pre_lfsr[5:0]));
      chk($sformatf("cyc%0d_y_range", c), int'(bus.CloudY >= 10'd260 && bus.CloudY <= 10'd323), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
